// File: rtl/piso_frame_shifter.sv
//------------------------------------------------------------------------------
// piso_frame_shifter
//
// Parallel-in / serial-out framing stage. A WIDTH-bit word is accepted over a
// valid/ready handshake and then emitted one bit per enabled cycle on `sout`.
// `sout` feeds the `d` input of the downstream flip-flop stage.
//
// Optional feature macro: PISO_PARITY_EN
//   defined   -> one even-parity bit (XOR of the data bits, computed when the
//                word is loaded) is appended after the last data bit. A frame
//                is then WIDTH+1 bits long and `frame_done` pulses on the
//                parity bit.
//   undefined -> a frame is WIDTH bits long and no parity logic exists.
//
// Parameters
//   WIDTH      data bits per frame (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset. Assertion clears the stage at
//               once; release is taken at a clock edge
//   load_valid  upstream word available
//   load_data   word to serialize, sampled only on an accepted load
//   load_ready  stage accepts a word at the next rising edge
//   shift_en    bit-rate enable; the current bit advances only when 1
//   sout        current serial bit (0 when no frame is active)
//   sout_valid  sout carries a frame bit
//   frame_done  high in the cycle whose closing edge consumes the final bit
//   dbg_state   registered FSM state (0 = IDLE, 1 = SHIFT) for observation
//
// Handshake: a word transfers on every rising edge where load_valid and
// load_ready are both 1, and only then. load_ready depends on registered
// state and shift_en, never on load_valid or load_data. While load_valid=1
// and load_ready=0 the producer holds load_data stable.
//------------------------------------------------------------------------------
module piso_frame_shifter #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             dbg_state
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  // Sized for WIDTH+1 so the parity build still fits FRAME-1 in the counter.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [FRAME-1:0]  sreg_q,  sreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [FRAME-1:0]  load_frame;
  logic [FRAME-1:0]  sreg_shifted;
  logic              cur_bit;
  logic              last_bit;

  // Word as it sits in the shift register: the bit that goes out first is at
  // the end the register shifts out of, and the parity bit (when built in) is
  // placed at the opposite end so it leaves last.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (MSB_FIRST != 0) begin
      load_frame = {load_data, ^load_data};
    end else begin
      load_frame = {^load_data, load_data};
    end
`else
    load_frame = load_data;
`endif
  end

  always_comb begin
    if (MSB_FIRST != 0) begin
      cur_bit      = sreg_q[FRAME-1];
      sreg_shifted = {sreg_q[FRAME-2:0], 1'b0};
    end else begin
      cur_bit      = sreg_q[0];
      sreg_shifted = {1'b0, sreg_q[FRAME-1:1]};
    end
  end

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == '0);

  // Next-state and output decode.
  //
  // On the last bit load_ready also requires shift_en: with shift_en=0 the
  // last bit is still being held on sout, so taking a new word that cycle
  // would either drop that bit or accept a word without capturing it.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sreg_d  = load_frame;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sout_valid = 1'b1;
        sout       = cur_bit;
        if (shift_en) begin
          if (last_bit) begin
            frame_done = 1'b1;
            load_ready = 1'b1;
            if (load_valid) begin
              // Back-to-back frame: next word's first bit follows directly.
              sreg_d  = load_frame;
              cnt_d   = CNT_LAST;
              state_d = ST_SHIFT;
            end else begin
              sreg_d  = '0;
              state_d = ST_IDLE;
            end
          end else begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q - CNT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_piso_frame_shifter.sv
//------------------------------------------------------------------------------
// tb_piso_frame_shifter
//
// Two instances run side by side on shared inputs: one MSB-first, one
// LSB-first. The reference model keeps, per instance, the queue of bits still
// to be sent for the active frame; expected outputs each cycle follow directly
// from that queue. Directed scenarios additionally compare the consumed bit
// stream against hand-written constants.
//------------------------------------------------------------------------------
module tb_piso_frame_shifter;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         shift_en   = 1'b0;

  always #5 clk = ~clk;

  logic m_ready, m_sout, m_valid, m_done, m_state;
  logic l_ready, l_sout, l_valid, l_done, l_state;

  piso_frame_shifter #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_ready), .shift_en(shift_en), .sout(m_sout),
    .sout_valid(m_valid), .frame_done(m_done), .dbg_state(m_state)
  );

  piso_frame_shifter #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_ready), .shift_en(shift_en), .sout(l_sout),
    .sout_valid(l_valid), .frame_done(l_done), .dbg_state(l_state)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_m_q[$];   // bits still to send, front = bit on sout now
  logic [0:0] exp_l_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  // Observation window for directed checks.
  logic [31:0] cap_m, cap_l;   // consumed bits, first bit ends up highest
  int          n_valid_m;
  int          cyc;
  int          done_q[$];      // cycle numbers of MSB-instance frame_done

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input bit msb_first, input logic [W-1:0] d);
    logic [0:0] b;
    for (int i = 0; i < W; i++) begin
      b = msb_first ? d[W-1-i] : d[i];
      if (msb_first) exp_m_q.push_back(b); else exp_l_q.push_back(b);
    end
`ifdef PISO_PARITY_EN
    b = ^d;
    if (msb_first) exp_m_q.push_back(b); else exp_l_q.push_back(b);
`endif
  endtask

  task automatic clear_cap();
    cap_m = '0; cap_l = '0; n_valid_m = 0; cyc = 0;
    done_q.delete();
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge with inputs already applied; checks at
  // the falling edge, advances the model at the rising edge, returns 1 time
  // unit after it. acc reports whether the word was taken at that edge.
  task automatic cycle(output bit acc);
    bit m_busy, l_busy, m_last, l_last, m_rdy, l_rdy;
    @(negedge clk);
    m_busy = exp_m_q.size() != 0;
    l_busy = exp_l_q.size() != 0;
    m_last = exp_m_q.size() == 1;
    l_last = exp_l_q.size() == 1;
    m_rdy  = !m_busy || (m_last && shift_en);
    l_rdy  = !l_busy || (l_last && shift_en);
    check("m_ready", m_ready, m_rdy);
    check("m_valid", m_valid, m_busy);
    check("m_sout",  m_sout,  m_busy ? exp_m_q[0] : 1'b0);
    check("m_done",  m_done,  m_last && shift_en);
    check("l_ready", l_ready, l_rdy);
    check("l_valid", l_valid, l_busy);
    check("l_sout",  l_sout,  l_busy ? exp_l_q[0] : 1'b0);
    check("l_done",  l_done,  l_last && shift_en);
    if (m_valid && shift_en) cap_m = {cap_m[30:0], m_sout};
    if (l_valid && shift_en) cap_l = {cap_l[30:0], l_sout};
    if (m_valid) n_valid_m++;
    if (m_done) done_q.push_back(cyc);
    cyc++;
    @(posedge clk);
    acc = 1'b0;
    if (!rst) begin
      exp_m_q.delete();
      exp_l_q.delete();
    end else begin
      if (m_busy && shift_en) void'(exp_m_q.pop_front());
      if (l_busy && shift_en) void'(exp_l_q.pop_front());
      if (load_valid && m_rdy) begin
        push_frame(1'b1, load_data);
        acc = 1'b1;
      end
      if (load_valid && l_rdy) push_frame(1'b0, load_data);
    end
    #1;
  endtask

  task automatic run(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit          acc;
    int          waited;
    bit          pending;
    logic [31:0] exp_stream;

    @(posedge clk); #1;

    // Reset then idle: outputs stay at reset values.
    rst = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
    run(3);
    rst = 1'b1;
    run(5);
    check("rst_state_m", m_state, 1'b0);

    // Single frame 8'hA5 with shift_en=1.
    load_valid = 1'b1; load_data = 8'hA5;
    cycle(acc);
    check("a5_accept", acc, 1'b1);
    load_valid = 1'b0;
    clear_cap();
    run(FRAME);
`ifdef PISO_PARITY_EN
    exp_stream = 32'h14A;   // 1,0,1,0,0,1,0,1 then parity 0
`else
    exp_stream = 32'hA5;
`endif
    check("a5_stream_m", cap_m, exp_stream);
    check("a5_stream_l", cap_l, exp_stream);
    check("a5_done_cnt", done_q.size(), 1);
    if (done_q.size() == 1) check("a5_done_pos", done_q[0], FRAME - 1);
    run(1);
    check("a5_idle_state", m_state, 1'b0);

    // Back-to-back 8'hF0 then 8'h0F.
    load_valid = 1'b1; load_data = 8'hF0;
    cycle(acc);
    load_data = 8'h0F;
    clear_cap();
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(acc);
      if (acc) load_valid = 1'b0;
    end
`ifdef PISO_PARITY_EN
    exp_stream = 32'h03DE0;   // 0000 1111 0 | 1111 0000 0
`else
    exp_stream = 32'h0FF0;    // 0000 1111 | 1111 0000
`endif
    check("b2b_stream_l", cap_l, exp_stream);
    check("b2b_valid_cnt", n_valid_m, 2 * FRAME);
    check("b2b_done_cnt", done_q.size(), 2);
    if (done_q.size() == 2) check("b2b_done_gap", done_q[1] - done_q[0], FRAME);
    run(1);

    // Pacing: shift_en alternates, each bit held two cycles.
    load_valid = 1'b1; load_data = 8'h81;
    cycle(acc);
    load_valid = 1'b0;
    clear_cap();
    for (int i = 0; i < 2 * FRAME; i++) begin
      shift_en = (i % 2) == 1;
      cycle(acc);
    end
    shift_en = 1'b1;
`ifdef PISO_PARITY_EN
    exp_stream = 32'h102;   // 1000 0001 then parity 0
`else
    exp_stream = 32'h81;
`endif
    check("pace_stream_m", cap_m, exp_stream);
    check("pace_valid_cnt", n_valid_m, 2 * FRAME);
    check("pace_done_cnt", done_q.size(), 1);
    if (done_q.size() == 1) check("pace_done_pos", done_q[0], 2 * FRAME - 1);
    run(1);

    // Reset mid-frame, asserted between clock edges.
    load_valid = 1'b1; load_data = 8'hFF;
    cycle(acc);
    load_valid = 1'b0;
    clear_cap();
    run(3);
    #2 rst = 1'b0;
    #1;
    exp_m_q.delete();
    exp_l_q.delete();
    check("abort_valid_m", m_valid, 1'b0);
    check("abort_sout_m",  m_sout,  1'b0);
    check("abort_done_m",  m_done,  1'b0);
    check("abort_valid_l", l_valid, 1'b0);
    check("abort_ready_m", m_ready, 1'b1);
    run(2);
    rst = 1'b1;
    check("abort_no_done", done_q.size(), 0);
    run(1);
    load_valid = 1'b1; load_data = 8'h01;
    cycle(acc);
    load_valid = 1'b0;
    clear_cap();
    run(FRAME);
`ifdef PISO_PARITY_EN
    check("post_rst_stream_l", cap_l, 32'h101);
    check("post_rst_stream_m", cap_m, 32'h003);
`else
    check("post_rst_stream_l", cap_l, 32'h80);
    check("post_rst_stream_m", cap_m, 32'h01);
`endif
    run(1);

    // Stall on busy: 8'h3C offered while bit 2 of the prior frame is out.
    load_valid = 1'b1; load_data = W'($urandom);
    cycle(acc);
    load_valid = 1'b0;
    run(2);
    load_valid = 1'b1; load_data = 8'h3C;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 4 * FRAME) begin
      cycle(acc);
      waited++;
    end
    load_valid = 1'b0;
    check("stall_accepted", acc, 1'b1);
    check("stall_wait", waited, FRAME - 2);
    clear_cap();
    run(FRAME);
    check("stall_valid_cnt", n_valid_m, FRAME);
`ifdef PISO_PARITY_EN
    check("stall_stream_m", cap_m, 32'h078);
`else
    check("stall_stream_m", cap_m, 32'h3C);
`endif
    run(1);

    // Random traffic; data held while a load is waiting.
    pending = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pending) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = W'($urandom);
      end
      shift_en = ($urandom_range(0, 3) != 0);
      cycle(acc);
      pending = load_valid && !acc;
    end
    load_valid = 1'b0;
    shift_en   = 1'b1;
    run(2 * FRAME);
    check("final_idle_m", m_valid, 1'b0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
